// File: rtl/mult_job_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mult_job_scheduler
//  Description : Round-robin arbiter and job sequencer that shares one
//                digit-serial multiplier engine between several requesters.
//                It latches the operands, pulses start, waits for done with a
//                timeout, returns a tagged result, then resets the engine
//                (whose DONE state is sticky).
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_job_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int ID_W       = 1,
    parameter int DATA_WIDTH = 8,
    parameter int N_DIGITAL  = 2,
    parameter int BWIDTH     = (DATA_WIDTH / N_DIGITAL + 1) * N_DIGITAL,
    parameter int TIMEOUT    = 64,
    parameter int CLR_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_g,
    input  logic [NUM_REQ*BWIDTH-1:0]     req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_t,
    output logic                          rsp_err,
    output logic                          mul_start,
    output logic [DATA_WIDTH-1:0]         mul_a,
    output logic [DATA_WIDTH-1:0]         mul_g,
    output logic [BWIDTH-1:0]             mul_b,
    output logic                          mul_rst_n,
    input  logic [DATA_WIDTH-1:0]         mul_t,
    input  logic                          mul_done
);

    localparam int c_TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_CLR_W = $clog2(CLR_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_CLR   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ID_W-1:0]         r_rr_ptr;
    logic [c_TMR_W-1:0]      r_timer;
    logic [c_CLR_W-1:0]      r_clr_cnt;
    logic [DATA_WIDTH-1:0]   r_mul_a;
    logic [DATA_WIDTH-1:0]   r_mul_g;
    logic [BWIDTH-1:0]       r_mul_b;
    logic                    r_mul_rst_n;
    logic [ID_W-1:0]         r_rsp_id;
    logic [DATA_WIDTH-1:0]   r_rsp_t;
    logic                    r_rsp_err;

    logic                    w_found;
    logic [ID_W-1:0]         w_grant_idx;
    int                      w_dist;
    int                      w_best;
    logic [DATA_WIDTH-1:0]   w_sel_a;
    logic [DATA_WIDTH-1:0]   w_sel_g;
    logic [BWIDTH-1:0]       w_sel_b;
    logic [NUM_REQ-1:0]      w_req_ready;
    logic                    w_timeout;
    logic                    w_clr_last;

    // Round-robin pick: the valid requester closest to rr_ptr (circular distance) wins
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_dist      = 0;
        w_best      = NUM_REQ;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_dist = (k + NUM_REQ - int'(r_rr_ptr)) % NUM_REQ;
            if (req_valid[k] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_grant_idx = ID_W'(k);
                w_found     = 1'b1;
            end
        end
    end

    // Operand mux and one-hot ready; ready is only ever offered while idle
    always_comb begin
        w_sel_a     = '0;
        w_sel_g     = '0;
        w_sel_b     = '0;
        w_req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant_idx == ID_W'(k)) begin
                w_sel_a = req_a[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_g = req_g[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_b = req_b[k*BWIDTH +: BWIDTH];
            end
            w_req_ready[k] = (r_state == S_IDLE) && w_found && (w_grant_idx == ID_W'(k));
        end
    end

    assign w_timeout  = (r_timer == c_TMR_W'(TIMEOUT - 1));
    assign w_clr_last = (r_clr_cnt == c_CLR_W'(CLR_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a grant in IDLE is always a handshake since ready follows valid
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  if (mul_done || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_CLR;
            S_CLR:   if (w_clr_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, timer, result capture and engine-clear sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_timer     <= '0;
            r_clr_cnt   <= '0;
            r_mul_a     <= '0;
            r_mul_g     <= '0;
            r_mul_b     <= '0;
            r_mul_rst_n <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_t     <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Engine leaves reset on the first edge after rst_n and stays out while idle
                    r_mul_rst_n <= 1'b1;
                    if (w_found) begin
                        r_mul_a  <= w_sel_a;
                        r_mul_g  <= w_sel_g;
                        r_mul_b  <= w_sel_b;
                        r_rsp_id <= w_grant_idx;
                        r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
                    end
                end
                S_START: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    r_timer <= r_timer + c_TMR_W'(1);
                    // done takes priority over a coincident timeout
                    if (mul_done) begin
                        r_rsp_t   <= mul_t;
                        r_rsp_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_t   <= '0;
                        r_rsp_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_mul_rst_n <= 1'b0;
                        r_clr_cnt   <= '0;
                    end
                end
                S_CLR: begin
                    if (w_clr_last) begin
                        r_mul_rst_n <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + c_CLR_W'(1);
                    end
                end
                default: begin
                    r_mul_rst_n <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_t     = r_rsp_t;
    assign rsp_err   = r_rsp_err;
    assign mul_start = (r_state == S_START);
    assign mul_a     = r_mul_a;
    assign mul_g     = r_mul_g;
    assign mul_b     = r_mul_b;
    assign mul_rst_n = r_mul_rst_n;

endmodule
`default_nettype wire
